exposure_sequencer: RTL and testbench

//  Sequences one X-ray exposure for the beam steering datapath: positioning prep, tube arm,

---
 rtl/exposure_sequencer_pkg.sv | 27 ++
 rtl/exposure_sequencer_if.sv | 25 ++
 rtl/exposure_sequencer_seq_timer.sv | 29 ++
 rtl/exposure_sequencer.sv | 140 ++++++++++++++
 tb/tb_exposure_sequencer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/exposure_sequencer_pkg.sv
// Shared types for the exposure sequencer: state encoding, fault codes and
// the sizing helper for the shared PREP/COOL timer.
package exposure_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_PREP   = 3'b001,
    ST_ARM    = 3'b010,
    ST_EXPOSE = 3'b011,
    ST_COOL   = 3'b100,
    ST_FAULT  = 3'b101
  } state_t;

  localparam logic [1:0] FC_NONE         = 2'b00;
  localparam logic [1:0] FC_PREP_TIMEOUT = 2'b01;
  localparam logic [1:0] FC_VIBRATION    = 2'b10;
  localparam logic [1:0] FC_INTERLOCK    = 2'b11;

  // One spare bit so the timer can step past its terminal value on the
  // leaving edge without wrapping, even for tiny parameter values.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/exposure_sequencer_if.sv
// Exposure request channel between the host controller and the sequencer.
interface exposure_sequencer_if #(
  parameter int DOSE_W = 8
);

  // A request transfers on any clock edge where req_valid && req_ready are both
  // high; req_dose is sampled on that edge. The master holds req_valid/req_dose
  // stable until the transfer, and req_ready does not depend on req_valid.
  logic              req_valid;
  logic              req_ready;
  logic [DOSE_W-1:0] req_dose;

  modport master (
    output req_valid,
    output req_dose,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_dose,
    output req_ready
  );

endinterface

// File: rtl/exposure_sequencer_seq_timer.sv
// Loadable up-counter with hold (en low) and a terminal-value flag; shared by
// the PREP timeout and the COOL dwell.
module seq_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         at_term
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign at_term = (count == term);

endmodule

// File: rtl/exposure_sequencer.sv
// X-ray exposure sequencer: PREP -> ARM -> dose-counted EXPOSE -> COOL, with
// interlock loss aborting into a latched FAULT that needs an operator clear.
module exposure_sequencer
  import exposure_pkg::*;
#(
  parameter int PREP_TIMEOUT = 64,
  parameter int COOL_CYCLES  = 32,
  parameter int DOSE_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  exposure_sequencer_if.slave req,
  input  logic               pos_ok,
  input  logic               power_ok,
  input  logic               temp_hot,
  input  logic               vib_alarm,
  input  logic               dose_pulse,
  input  logic               fault_clr,
  output logic               prep_req,
  output logic               xray_en,
  output logic               shutter_open,
  output logic               done,
  output logic               fault,
  output logic [1:0]         fault_code,
  output logic [DOSE_W-1:0]  dose_count,
  output logic [2:0]         state_dbg
);

  localparam int TMR_W = timer_width(PREP_TIMEOUT, COOL_CYCLES);

  state_t            state;
  logic [DOSE_W-1:0] dose_target;
  logic [DOSE_W-1:0] dose_next;
  logic              ilk_ready;
  logic              ilk_trip;
  logic [1:0]        ilk_code;
  logic              timer_load;
  logic              timer_en;
  logic [TMR_W-1:0]  timer_term;
  logic              timer_done;

  assign ilk_ready = pos_ok && power_ok && !temp_hot;
  assign ilk_trip  = vib_alarm || !power_ok || temp_hot || !pos_ok;
  assign ilk_code  = vib_alarm ? FC_VIBRATION : FC_INTERLOCK;
  assign dose_next = dose_count + 1'b1;

  // PREP and COOL are only ever entered from states where the timer sits
  // cleared, so holding it at zero elsewhere gives a fresh count on entry.
  assign timer_load = (state != ST_PREP) && (state != ST_COOL);
  assign timer_en   = (state == ST_PREP) || ((state == ST_COOL) && !temp_hot);
  assign timer_term = (state == ST_PREP) ? TMR_W'(PREP_TIMEOUT - 1)
                                         : TMR_W'(COOL_CYCLES - 1);

  seq_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val ('0),
    .en       (timer_en),
    .term     (timer_term),
    .at_term  (timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      done        <= 1'b0;
      fault_code  <= FC_NONE;
      dose_count  <= '0;
      dose_target <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req.req_valid && req.req_ready) begin
            if (req.req_dose != '0) begin
              dose_target <= req.req_dose;
              dose_count  <= '0;
              state       <= ST_PREP;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_PREP: begin
          if (ilk_ready) begin
            state <= ST_ARM;
          end else if (timer_done) begin
            state      <= ST_FAULT;
            fault_code <= FC_PREP_TIMEOUT;
          end
        end
        ST_ARM: begin
          if (ilk_trip) begin
            state      <= ST_FAULT;
            fault_code <= ilk_code;
          end else begin
            state <= ST_EXPOSE;
          end
        end
        ST_EXPOSE: begin
          // The pulse is counted even when an interlock trips on the same edge;
          // the trip still wins over completion.
          if (dose_pulse) begin
            dose_count <= dose_next;
          end
          if (ilk_trip) begin
            state      <= ST_FAULT;
            fault_code <= ilk_code;
          end else if (dose_pulse && (dose_next == dose_target)) begin
            state <= ST_COOL;
            done  <= 1'b1;
          end
        end
        ST_COOL: begin
          if (!temp_hot && timer_done) begin
            state <= ST_IDLE;
          end
        end
        ST_FAULT: begin
          if (fault_clr && power_ok && !temp_hot && !vib_alarm) begin
            state      <= ST_IDLE;
            fault_code <= FC_NONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req.req_ready = (state == ST_IDLE);
  assign prep_req      = (state == ST_PREP);
  assign xray_en       = (state == ST_ARM) || (state == ST_EXPOSE);
  assign shutter_open  = (state == ST_EXPOSE);
  assign fault         = (state == ST_FAULT);
  assign state_dbg     = state;

endmodule

// File: tb/tb_exposure_sequencer.sv
// Directed walk through the exposure scenarios followed by randomized
// exposures checked against a cycle-count / pulse-count reference model.
module tb_exposure_sequencer;
  import exposure_pkg::*;

  localparam int DOSE_W       = 8;
  localparam int PREP_TIMEOUT = 64;
  localparam int COOL_CYCLES  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pos_ok, power_ok, temp_hot, vib_alarm, dose_pulse, fault_clr;
  logic              prep_req, xray_en, shutter_open, done, fault;
  logic [1:0]        fault_code;
  logic [DOSE_W-1:0] dose_count;
  logic [2:0]        state_dbg;

  int checks = 0;
  int errors = 0;
  logic [DOSE_W-1:0] exp_q[$];

  exposure_sequencer_if #(.DOSE_W(DOSE_W)) req_if ();

  exposure_sequencer #(
    .PREP_TIMEOUT (PREP_TIMEOUT),
    .COOL_CYCLES  (COOL_CYCLES),
    .DOSE_W       (DOSE_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req_if),
    .pos_ok       (pos_ok),
    .power_ok     (power_ok),
    .temp_hot     (temp_hot),
    .vib_alarm    (vib_alarm),
    .dose_pulse   (dose_pulse),
    .fault_clr    (fault_clr),
    .prep_req     (prep_req),
    .xray_en      (xray_en),
    .shutter_open (shutter_open),
    .done         (done),
    .fault        (fault),
    .fault_code   (fault_code),
    .dose_count   (dose_count),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic start_req(input logic [DOSE_W-1:0] d);
    req_if.req_valid = 1'b1;
    req_if.req_dose  = d;
    tick();
    req_if.req_valid = 1'b0;
  endtask

  task automatic pulse();
    dose_pulse = 1'b1;
    tick();
    dose_pulse = 1'b0;
  endtask

  task automatic go_expose(input string tag, input logic [DOSE_W-1:0] d);
    start_req(d);
    check({tag, "_prep_st"}, state_dbg, ST_PREP);
    check({tag, "_prep_req"}, prep_req, 1'b1);
    tick();
    check({tag, "_arm_st"}, state_dbg, ST_ARM);
    check({tag, "_arm_io"}, {xray_en, shutter_open}, 2'b10);
    tick();
    check({tag, "_exp_st"}, state_dbg, ST_EXPOSE);
    check({tag, "_exp_io"}, {xray_en, shutter_open, prep_req}, 3'b110);
  endtask

  // Runs COOL to completion (bounded); temp_hot is raised for hot_len edges
  // from hot_start, followed by vibration/position noise and stray dose pulses
  // that COOL must ignore. n returns the number of cycles spent in COOL.
  task automatic run_cool(input int hot_start, input int hot_len, output int n);
    n = 0;
    while (state_dbg == ST_COOL && n < 200) begin
      temp_hot   = (n >= hot_start) && (n < hot_start + hot_len);
      vib_alarm  = (n >= hot_start + hot_len) && (n < hot_start + hot_len + 3);
      pos_ok     = !vib_alarm;
      dose_pulse = 1'($urandom_range(0, 1));
      tick();
      n++;
      if (n == 1) check("cool_done_drop", done, 1'b0);
    end
    temp_hot = 1'b0; vib_alarm = 1'b0; pos_ok = 1'b1; dose_pulse = 1'b0;
  endtask

  task automatic clear_fault();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
  endtask

  initial begin
    int n;
    int tgt;
    int gap;
    int d_pos;
    req_if.req_valid = 1'b0;
    req_if.req_dose  = '0;
    pos_ok = 1'b1; power_ok = 1'b1; temp_hot = 1'b0;
    vib_alarm = 1'b0; dose_pulse = 1'b0; fault_clr = 1'b0;

    tick();
    tick();
    check("rst_state", state_dbg, ST_IDLE);
    check("rst_outs", {prep_req, xray_en, shutter_open, done, fault}, 5'b0);
    check("rst_code", fault_code, FC_NONE);
    check("rst_dose", dose_count, 0);
    check("rst_ready", req_if.req_ready, 1'b1);
    rst = 1'b0;
    tick();

    // 1: nominal exposure of 3 pulses
    go_expose("t1", 8'd3);
    for (int p = 1; p <= 3; p++) begin
      repeat ($urandom_range(0, 2)) tick();
      pulse();
      check("t1_dose", dose_count, p);
      check("t1_done", done, (p == 3));
    end
    check("t1_cool_st", state_dbg, ST_COOL);
    check("t1_cool_io", {xray_en, shutter_open, prep_req}, 3'b000);
    run_cool(COOL_CYCLES + 10, 0, n);
    check("t1_cool_len", n, COOL_CYCLES);
    check("t1_idle_ready", req_if.req_ready, 1'b1);
    check("t1_dose_hold", dose_count, 3);

    // 2: positioning never arrives -> PREP timeout
    pos_ok = 1'b0;
    start_req(8'($urandom_range(1, 255)));
    repeat (PREP_TIMEOUT - 1) tick();
    check("t2_still_prep", state_dbg, ST_PREP);
    tick();
    check("t2_fault_st", state_dbg, ST_FAULT);
    check("t2_fault", {fault, fault_code}, {1'b1, FC_PREP_TIMEOUT});
    check("t2_fault_io", {req_if.req_ready, prep_req, xray_en}, 3'b000);
    clear_fault();
    check("t2_clr_st", state_dbg, ST_IDLE);
    check("t2_clr_code", {fault, fault_code}, 3'b000);
    pos_ok = 1'b1;

    // 3: vibration after 1 of 5 pulses
    go_expose("t3", 8'd5);
    pulse();
    vib_alarm = 1'b1;
    tick();
    check("t3_fault", {state_dbg, fault_code}, {ST_FAULT, FC_VIBRATION});
    check("t3_io", {xray_en, shutter_open, done}, 3'b000);
    check("t3_dose", dose_count, 1);
    clear_fault();
    check("t3_clr_blocked", state_dbg, ST_FAULT);
    vib_alarm = 1'b0;
    clear_fault();
    check("t3_clr_ok", state_dbg, ST_IDLE);

    // 4: final pulse coincides with power loss
    tgt = $urandom_range(2, 6);
    go_expose("t4", 8'(tgt));
    for (int p = 1; p < tgt; p++) begin
      pulse();
      check("t4_no_done", done, 1'b0);
    end
    power_ok = 1'b0;
    pulse();
    check("t4_fault", {state_dbg, fault_code}, {ST_FAULT, FC_INTERLOCK});
    check("t4_done", done, 1'b0);
    check("t4_dose", dose_count, tgt);
    tick();
    check("t4_done_later", done, 1'b0);
    clear_fault();
    check("t4_clr_blocked", state_dbg, ST_FAULT);
    power_ok = 1'b1;
    clear_fault();
    check("t4_clr_ok", state_dbg, ST_IDLE);

    // 5: temp_hot stretches COOL, then zero-dose request
    go_expose("t5", 8'd1);
    pulse();
    check("t5_done", {done, state_dbg}, {1'b1, ST_COOL});
    run_cool($urandom_range(2, 10), 10, n);
    check("t5_cool_len", n, COOL_CYCLES + 10);
    start_req(8'd0);
    check("t5_zero_done", {done, state_dbg}, {1'b1, ST_IDLE});
    tick();
    check("t5_zero_pulse", {done, req_if.req_ready}, 2'b01);

    // 6: reset in the middle of an exposure
    go_expose("t6", 8'd5);
    pulse();
    rst = 1'b1;
    tick();
    check("t6_state", state_dbg, ST_IDLE);
    check("t6_outs", {prep_req, xray_en, shutter_open, done, fault}, 5'b0);
    check("t6_code_dose", {fault_code, dose_count}, 10'b0);
    check("t6_ready", req_if.req_ready, 1'b1);
    rst = 1'b0;
    tick();

    // randomized exposures: late positioning, stray pulses, busy requests
    for (int k = 0; k < 6; k++) begin
      tgt   = $urandom_range(1, 12);
      d_pos = $urandom_range(0, 20);
      pos_ok = (d_pos == 0);
      start_req(8'(tgt));
      repeat (d_pos) tick();
      check("r_prep", state_dbg, ST_PREP);
      pos_ok = 1'b1;
      dose_pulse = 1'b1;
      tick();
      check("r_arm", state_dbg, ST_ARM);
      tick();
      dose_pulse = 1'b0;
      check("r_exp", {state_dbg, dose_count}, {ST_EXPOSE, 8'd0});
      for (int p = 1; p <= tgt; p++) exp_q.push_back(8'(p));
      while (exp_q.size() > 0) begin
        gap = $urandom_range(0, 3);
        req_if.req_valid = 1'($urandom_range(0, 1));
        req_if.req_dose  = 8'($urandom_range(0, 255));
        repeat (gap) tick();
        check("r_busy", req_if.req_ready, 1'b0);
        pulse();
        check("r_dose", dose_count, exp_q.pop_front());
        check("r_done", done, (exp_q.size() == 0));
      end
      req_if.req_valid = 1'b0;
      run_cool(COOL_CYCLES + 10, 0, n);
      check("r_cool_len", n, COOL_CYCLES);
      check("r_dose_hold", dose_count, tgt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
